// File: rtl/game_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_timer_ctrl
// Purpose  : Level-timing sequencer for the BCD stopwatch: run/clear control,
//            lap and best-time capture, HEX display selection.
// Revision : 1.0 - initial release
// ============================================================================
module game_timer_ctrl #(
  parameter logic [15:0] TIME_LIMIT = 16'h3000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       game_start,
  input  logic       pause_btn,
  input  logic       pacman_dead,
  input  logic       level_clear,
  input  logic       show_best,
  input  logic [3:0] sw_hex0,
  input  logic [3:0] sw_hex1,
  input  logic [3:0] sw_hex2,
  input  logic [3:0] sw_hex3,
  output logic       sw_start,
  output logic       sw_reset,
  output logic [3:0] disp_hex0,
  output logic [3:0] disp_hex1,
  output logic [3:0] disp_hex2,
  output logic [3:0] disp_hex3,
  output logic [2:0] state,
  output logic       timeout,
  output logic       best_valid,
  output logic       new_best
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_ARM   = 3'd1;
  localparam logic [2:0] c_RUN   = 3'd2;
  localparam logic [2:0] c_PAUSE = 3'd3;
  localparam logic [2:0] c_CLEAR = 3'd4;
  localparam logic [2:0] c_OVER  = 3'd5;

  logic [2:0]  r_state;
  logic [2:0]  w_state_next;
  logic [15:0] w_live;
  logic        w_limit_hit;
  logic        w_take_best;
  logic        r_timeout;
  logic        r_best_valid;
  logic        r_new_best;
  logic [15:0] r_best;
  logic [15:0] r_lap;
  logic [15:0] w_disp;

  // Packed BCD compares as plain unsigned: digit weights are fixed, digits <= 9.
  assign w_live      = {sw_hex3, sw_hex2, sw_hex1, sw_hex0};
  assign w_limit_hit = (r_state == c_RUN) && !level_clear && !pacman_dead
                       && (w_live == TIME_LIMIT);
  assign w_take_best = (r_state == c_RUN) && level_clear
                       && (!r_best_valid || (w_live < r_best));

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= c_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE:  if (game_start) w_state_next = c_ARM;
      c_ARM:   w_state_next = c_RUN;
      c_RUN: begin
        if (level_clear)      w_state_next = c_CLEAR;
        else if (pacman_dead) w_state_next = c_OVER;
        else if (w_limit_hit) w_state_next = c_OVER;
        else if (pause_btn)   w_state_next = c_PAUSE;
      end
      c_PAUSE: begin
        if (pacman_dead)      w_state_next = c_OVER;
        else if (game_start)  w_state_next = c_ARM;
        else if (pause_btn)   w_state_next = c_RUN;
      end
      c_CLEAR, c_OVER: if (game_start) w_state_next = c_ARM;
      default: w_state_next = c_IDLE;
    endcase
  end

  always_comb begin
    sw_start = (r_state == c_RUN);
    sw_reset = (r_state == c_ARM);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_timeout    <= 1'b0;
      r_best_valid <= 1'b0;
      r_new_best   <= 1'b0;
      r_best       <= 16'h0000;
      r_lap        <= 16'h0000;
    end else begin
      r_new_best <= w_take_best;
      if (w_state_next == c_ARM) r_timeout <= 1'b0;
      else if (w_limit_hit)      r_timeout <= 1'b1;
      if ((r_state == c_RUN) && level_clear) r_lap <= w_live;
      if (w_take_best) begin
        r_best       <= w_live;
        r_best_valid <= 1'b1;
      end
    end
  end

  always_comb begin
    if (show_best)             w_disp = r_best_valid ? r_best : 16'h0000;
    else if (r_state == c_CLEAR) w_disp = r_lap;
    else                       w_disp = w_live;
  end

  assign {disp_hex3, disp_hex2, disp_hex1, disp_hex0} = w_disp;
  assign state      = r_state;
  assign timeout    = r_timeout;
  assign best_valid = r_best_valid;
  assign new_best   = r_new_best;

endmodule
`default_nettype wire

// File: tb/tb_game_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_timer_ctrl
// Purpose  : Randomized bench for game_timer_ctrl against a time-in-tenths model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_timer_ctrl;

  localparam logic [15:0] c_LIMIT = 16'h3000;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       game_start, pause_btn, pacman_dead, level_clear, show_best;
  logic [3:0] sw_hex0, sw_hex1, sw_hex2, sw_hex3;
  logic       sw_start, sw_reset, timeout, best_valid, new_best;
  logic [3:0] disp_hex0, disp_hex1, disp_hex2, disp_hex3;
  logic [2:0] state;

  game_timer_ctrl #(.TIME_LIMIT(c_LIMIT)) dut (
    .Clk(Clk), .Reset(Reset),
    .game_start(game_start), .pause_btn(pause_btn),
    .pacman_dead(pacman_dead), .level_clear(level_clear), .show_best(show_best),
    .sw_hex0(sw_hex0), .sw_hex1(sw_hex1), .sw_hex2(sw_hex2), .sw_hex3(sw_hex3),
    .sw_start(sw_start), .sw_reset(sw_reset),
    .disp_hex0(disp_hex0), .disp_hex1(disp_hex1),
    .disp_hex2(disp_hex2), .disp_hex3(disp_hex3),
    .state(state), .timeout(timeout), .best_valid(best_valid), .new_best(new_best)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: state codes plus a scoreboard of lap/best kept as packed BCD.
  int          m_state;
  bit          m_to, m_bv, m_nb;
  logic [15:0] m_best, m_lap;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int tenths(input logic [15:0] v);
    return int'(v[15:12]) * 600 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  task automatic model_reset();
    m_state = 0; m_to = 0; m_bv = 0; m_nb = 0; m_best = 16'h0; m_lap = 16'h0;
  endtask

  task automatic model_step(input logic [15:0] l);
    int nxt;
    nxt  = m_state;
    m_nb = 0;
    case (m_state)
      0: if (game_start) nxt = 1;
      1: nxt = 2;
      2: begin
        if (level_clear) begin
          nxt   = 4;
          m_lap = l;
          if (!m_bv || tenths(l) < tenths(m_best)) begin
            m_best = l; m_bv = 1; m_nb = 1;
          end
        end else if (pacman_dead) nxt = 5;
        else if (tenths(l) == tenths(c_LIMIT)) begin
          nxt = 5; m_to = 1;
        end else if (pause_btn) nxt = 3;
      end
      3: begin
        if (pacman_dead)     nxt = 5;
        else if (game_start) nxt = 1;
        else if (pause_btn)  nxt = 2;
      end
      default: if (game_start) nxt = 1;
    endcase
    if (nxt == 1) m_to = 0;
    m_state = nxt;
  endtask

  initial begin
    logic [15:0] l, exp_disp;
    Reset = 1'b1;
    {game_start, pause_btn, pacman_dead, level_clear, show_best} = '0;
    {sw_hex3, sw_hex2, sw_hex1, sw_hex0} = 16'h0;
    repeat (2) @(posedge Clk);
    model_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      #1;
      Reset       = (cyc < 1) || ($urandom_range(0, 299) == 0);
      game_start  = ($urandom_range(0, 5) == 0);
      pause_btn   = ($urandom_range(0, 7) == 0);
      pacman_dead = ($urandom_range(0, 24) == 0);
      level_clear = ($urandom_range(0, 9) == 0);
      show_best   = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 9))
        0, 1:    l = c_LIMIT;
        2:       l = m_bv ? m_best : 16'h0123;
        default: l = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 5)),
                      4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      endcase
      {sw_hex3, sw_hex2, sw_hex1, sw_hex0} = l;
      #1;
      if (show_best)         exp_disp = m_bv ? m_best : 16'h0000;
      else if (m_state == 4) exp_disp = m_lap;
      else                   exp_disp = l;
      check("state",      16'(state),      16'(m_state));
      check("sw_start",   16'(sw_start),   16'(m_state == 2));
      check("sw_reset",   16'(sw_reset),   16'(m_state == 1));
      check("timeout",    16'(timeout),    16'(m_to));
      check("best_valid", 16'(best_valid), 16'(m_bv));
      check("new_best",   16'(new_best),   16'(m_nb));
      check("disp", {disp_hex3, disp_hex2, disp_hex1, disp_hex0}, exp_disp);
      if (Reset) model_reset();
      else       model_step(l);
      @(posedge Clk);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
